// File: rtl/demux_stage.sv
// ---------------------------------------------------------------------------
// demux_stage
//
// Purpose:
//   One-input, two-output demultiplexing stage with valid/ready handshakes.
//   Each accepted word is steered to lane 0 or lane 1 by in_sel and buffered
//   in that lane's own 2-entry FIFO. The occupancy of each lane is kept by a
//   small EMPTY/ONE/FULL state machine; the oldest word of a lane is held in
//   a dedicated head register so outN_data comes straight from a flop.
//
// Ports:
//   clk         - clock, rising edge active
//   reset       - asynchronous, active-high reset (empties both lanes)
//   in_valid    - upstream word valid
//   in_ready    - stage can accept a word for the lane chosen by in_sel
//   in_data     - upstream word (WIDTH bits)
//   in_sel      - destination lane (0 or 1), sampled with in_data
//   out0_valid  - lane 0 holds at least one word
//   out0_ready  - lane 0 consumer takes the word
//   out0_data   - oldest word of lane 0
//   out1_valid  - lane 1 holds at least one word
//   out1_ready  - lane 1 consumer takes the word
//   out1_data   - oldest word of lane 1
//   cnt0, cnt1  - (only with DEMUX_STAGE_COUNT_EN) saturating 16-bit pop
//                 counters for lane 0 and lane 1
//
// Build option:
//   DEMUX_STAGE_COUNT_EN - when defined, adds the cnt0/cnt1 pop counters.
// ---------------------------------------------------------------------------
module demux_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data
`ifdef DEMUX_STAGE_COUNT_EN
    ,
    output logic [15:0]      cnt0,
    output logic [15:0]      cnt1
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } lane_state_t;

    lane_state_t      r_state     [2];
    lane_state_t      w_state_nxt [2];

    logic [1:0]       w_valid;
    logic [1:0]       w_not_full;
    logic [1:0]       w_push;
    logic [1:0]       w_pop;
    logic [1:0]       w_out_ready;

    logic [WIDTH-1:0] r_mem  [2][2];
    logic [WIDTH-1:0] r_head [2];
    logic [1:0]       r_wptr;
    logic [1:0]       r_rptr;

    assign w_out_ready = {out1_ready, out0_ready};

    // in_ready looks only at the selected lane's occupancy, so a FULL lane
    // refuses a push even in the cycle it is being popped.
    assign in_ready = in_sel ? w_not_full[1] : w_not_full[0];
    assign w_push   = {in_valid & in_ready & in_sel, in_valid & in_ready & ~in_sel};
    assign w_pop    = w_valid & w_out_ready;

    // Lane occupancy state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state[0] <= S_EMPTY;
            r_state[1] <= S_EMPTY;
        end else begin
            r_state[0] <= w_state_nxt[0];
            r_state[1] <= w_state_nxt[1];
        end
    end

    // Lane occupancy next-state logic
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            w_state_nxt[n] = r_state[n];
            case (r_state[n])
                S_EMPTY: if (w_push[n]) w_state_nxt[n] = S_ONE;
                S_ONE: begin
                    if (w_push[n] && !w_pop[n])      w_state_nxt[n] = S_FULL;
                    else if (w_pop[n] && !w_push[n]) w_state_nxt[n] = S_EMPTY;
                end
                // A push into FULL cannot happen because in_ready is low.
                S_FULL:  if (w_pop[n]) w_state_nxt[n] = S_ONE;
                default: w_state_nxt[n] = S_EMPTY;
            endcase
        end
    end

    // Lane occupancy outputs
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            w_valid[n]    = (r_state[n] != S_EMPTY);
            w_not_full[n] = (r_state[n] != S_FULL);
        end
    end

    // Storage array needs no reset: it is only read through r_head, which
    // is reloaded before any stale entry could become visible.
    always_ff @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (w_push[n]) r_mem[n][r_wptr[n]] <= in_data;
        end
    end

    // Pointers and head register. The head tracks mem[rptr]: it is loaded
    // with the incoming word when that word becomes the oldest one (push
    // into EMPTY, or push+pop in ONE), and with the second entry when a
    // FULL lane is popped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_head[0] <= '0;
            r_head[1] <= '0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (w_push[n]) r_wptr[n] <= ~r_wptr[n];
                if (w_pop[n])  r_rptr[n] <= ~r_rptr[n];
                if (w_push[n] && (r_state[n] == S_EMPTY ||
                                  (r_state[n] == S_ONE && w_pop[n]))) begin
                    r_head[n] <= in_data;
                end else if (w_pop[n] && r_state[n] == S_FULL) begin
                    r_head[n] <= r_mem[n][~r_rptr[n]];
                end
            end
        end
    end

    assign out0_valid = w_valid[0];
    assign out1_valid = w_valid[1];
    assign out0_data  = r_head[0];
    assign out1_data  = r_head[1];

`ifdef DEMUX_STAGE_COUNT_EN
    logic [15:0] r_cnt0;
    logic [15:0] r_cnt1;

    // Pop counters saturate instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_pop[0] && r_cnt0 != 16'hFFFF) r_cnt0 <= r_cnt0 + 16'd1;
            if (w_pop[1] && r_cnt1 != 16'hFFFF) r_cnt1 <= r_cnt1 + 16'd1;
        end
    end

    assign cnt0 = r_cnt0;
    assign cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_demux_stage.sv
// ---------------------------------------------------------------------------
// tb_demux_stage
//
// Testbench for demux_stage. A reference model keeps one queue of expected
// words per lane; a monitor compares the DUT against it on every falling
// clock edge and updates the queues for the handshakes that will happen at
// the following rising edge. Directed sequences cover the corner cases and
// a randomized phase exercises arbitrary traffic.
// ---------------------------------------------------------------------------
module tb_demux_stage;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;
`ifdef DEMUX_STAGE_COUNT_EN
    logic [15:0]      cnt0;
    logic [15:0]      cnt1;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];

    demux_stage #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data)
`ifdef DEMUX_STAGE_COUNT_EN
        ,
        .cnt0       (cnt0),
        .cnt1       (cnt1)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor / scoreboard: inputs are stable here, half a cycle before the
    // edge at which the handshakes take effect.
    always @(negedge clk) begin
        logic exp_rdy;
        if (reset) begin
            q0.delete();
            q1.delete();
        end else begin
            exp_rdy = in_sel ? (q1.size() < 2) : (q0.size() < 2);
            check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
            check("out0_valid", {31'd0, out0_valid}, {31'd0, q0.size() != 0});
            check("out1_valid", {31'd0, out1_valid}, {31'd0, q1.size() != 0});
            if (q0.size() != 0) check("out0_data", out0_data, q0[0]);
            if (q1.size() != 0) check("out1_data", out1_data, q1[0]);
            if (q0.size() != 0 && out0_ready) void'(q0.pop_front());
            if (q1.size() != 0 && out1_ready) void'(q1.pop_front());
            if (in_valid && exp_rdy) begin
                if (in_sel) q1.push_back(in_data);
                else        q0.push_back(in_data);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_sel     = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst out0_valid", {31'd0, out0_valid}, 32'd0);
        check("rst out1_valid", {31'd0, out1_valid}, 32'd0);
        check("rst out0_data", out0_data, 32'd0);
        check("rst out1_data", out1_data, 32'd0);
        check("rst in_ready sel0", {31'd0, in_ready}, 32'd1);
        in_sel = 1'b1;
        #1;
        check("rst in_ready sel1", {31'd0, in_ready}, 32'd1);
        reset = 1'b0;

        // Single push to lane 0, one-cycle latency
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h0000_00AA; out0_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("lat out0_valid", {31'd0, out0_valid}, 32'd1);
        check("lat out0_data", out0_data, 32'h0000_00AA);
        check("lat out1_valid", {31'd0, out1_valid}, 32'd0);
        tick();
        check("lat drained", {31'd0, out0_valid}, 32'd0);

        // Lane 1 fills, third push refused until the lane leaves FULL
        out0_ready = 1'b0; out1_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b1; in_data = 32'h11;
        tick();
        in_data = 32'h22;
        tick();
        in_data = 32'h33;
        check("full in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        check("full hold data", out1_data, 32'h11);
        out1_ready = 1'b1;
        check("full pop cycle in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        check("pop1 order", out1_data, 32'h22);
        check("one in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("pop2 then 33", out1_data, 32'h33);
        tick();
        check("lane1 drained", {31'd0, out1_valid}, 32'd0);

        // Lane 1 FULL does not block lane 0
        out1_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b1; in_data = 32'hA1;
        tick();
        in_data = 32'hA2;
        tick();
        in_sel = 1'b0; in_data = 32'h55;
        #1;
        check("lane0 ready w/ lane1 full", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("lane0 got 55", out0_data, 32'h55);
        check("lane1 head kept", out1_data, 32'hA1);

        // Lane 0 in ONE: simultaneous push and pop
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h66; out0_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("pushpop valid", {31'd0, out0_valid}, 32'd1);
        check("pushpop data", out0_data, 32'h66);
        tick();
        check("pushpop drained", {31'd0, out0_valid}, 32'd0);

        // Both lanes FULL, then reset between edges
        out0_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hB1;
        tick();
        in_data = 32'hB2;
        tick();
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("midrst out0_valid", {31'd0, out0_valid}, 32'd0);
        check("midrst out1_valid", {31'd0, out1_valid}, 32'd0);
        check("midrst out0_data", out0_data, 32'd0);
        check("midrst in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        reset = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h77; out0_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("post-rst first word", out0_data, 32'h77);
        check("post-rst lane1 empty", {31'd0, out1_valid}, 32'd0);
        tick();

`ifdef DEMUX_STAGE_COUNT_EN
        reset = 1'b1;
        #1;
        check("cnt0 rst", {16'd0, cnt0}, 32'd0);
        tick();
        reset = 1'b0;
        out0_ready = 1'b1; out1_ready = 1'b1; in_sel = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'hC0 + i;
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("cnt0 three", {16'd0, cnt0}, 32'd3);
        check("cnt1 zero", {16'd0, cnt1}, 32'd0);
        force dut.r_cnt0 = 16'hFFFF;
        #1;
        release dut.r_cnt0;
        in_valid = 1'b1; in_data = 32'hD0;
        tick();
        in_valid = 1'b0;
        tick();
        check("cnt0 saturate", {16'd0, cnt0}, 32'h0000_FFFF);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_sel     = 1'($urandom_range(0, 1));
            in_data    = $urandom;
            out0_ready = ($urandom_range(0, 2) != 0);
            out1_ready = ($urandom_range(0, 2) == 0);
            tick();
        end
        in_valid = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_stage.md
DEMUX_STAGE -- requirements
Module: demux_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the data word width in bits.
REQ-002 SHALL have port clk, input, 1 bit; the single clock, rising-edge active.
REQ-003 SHALL have port reset, input, 1 bit; asynchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit; the upstream word is valid.
REQ-005 SHALL have port in_ready, output, 1 bit; the stage accepts the upstream word.
REQ-006 SHALL have port in_data, input, WIDTH bits; the upstream word.
REQ-007 SHALL have port in_sel, input, 1 bit; the destination lane (0 or 1), sampled with in_data.
REQ-008 SHALL have ports out0_valid (output, 1 bit), out0_ready (input, 1 bit) and out0_data (output, WIDTH bits) for lane 0.
REQ-009 SHALL have ports out1_valid (output, 1 bit), out1_ready (input, 1 bit) and out1_data (output, WIDTH bits) for lane 1.

Function
REQ-010 SHALL transfer an input word when in_valid and in_ready are both high at a clk rising edge (push); the word goes to the lane given by in_sel.
REQ-011 SHALL transfer an output word on lane n when outn_valid and outn_ready are both high at a clk rising edge (pop).
REQ-012 SHALL buffer each lane in its own 2-entry FIFO, tracked by an occupancy state machine per lane: EMPTY, ONE, FULL.
REQ-013 SHALL move each lane's state as follows:
- push only: EMPTY->ONE, ONE->FULL.
- pop only: FULL->ONE, ONE->EMPTY.
- push and pop together: no state change.
REQ-014 SHALL drive in_ready high exactly when the lane selected by in_sel is not FULL.
REQ-015 SHALL NOT make in_ready depend on in_valid or on any outn_ready; a FULL lane refuses a push even in the cycle it is popped.
REQ-016 SHALL drive outn_valid high exactly when lane n is not EMPTY.
REQ-017 SHALL drive outn_data from the oldest entry of lane n, directly from a register.
REQ-018 SHALL keep outn_data stable while outn_valid is high and outn_ready is low.
REQ-019 SHALL have a latency of 1 cycle: a word pushed into an EMPTY lane at edge k shows outn_valid=1 after edge k.
REQ-020 SHALL preserve FIFO order within each lane; no ordering is guaranteed between the two lanes.
REQ-021 SHALL allow both lanes to pop in the same cycle, independently.
REQ-022 SHALL wrap the 1-bit read and write pointers of each lane modulo 2.
REQ-023 SHALL NOT change any state on a push refused by in_ready=0, and SHALL NOT change any state when a lane is popped while EMPTY (outn_valid=0).

Reset
REQ-024 SHALL force both lanes to EMPTY and all pointers to 0 immediately on reset high, regardless of clk.
REQ-025 SHALL hold outn_valid=0 and outn_data=0 for both lanes while reset is high.
REQ-026 SHALL drive in_ready as the REQ-014 function of in_sel while reset is high (1 for either lane, since both are empty).
REQ-027 SHALL discard any buffered words when reset is asserted mid-operation.
REQ-028 SHALL accept the first push at the first rising edge after reset is released.

Configuration
REQ-029 SHALL, when macro DEMUX_STAGE_COUNT_EN is defined, add output ports cnt0 and cnt1 (16 bits each).
- Each counts pops on its lane, saturating at 16'hFFFF.
- Both reset to 0.
REQ-030 SHALL, when DEMUX_STAGE_COUNT_EN is undefined, omit cnt0 and cnt1 and all counter logic, with all other behaviour identical.

Verification
REQ-031 SHALL cover: reset, then push 32'h0000_00AA with sel=0 while out0_ready=1 -> out0_valid=1 and out0_data=32'h0000_00AA one cycle later; out1_valid stays 0.
REQ-032 SHALL cover: out1_ready=0, push 32'h11, 32'h22, then 32'h33 with sel=1 -> in_ready=0 on the third push; after out1_ready=1, pops are 32'h11 then 32'h22; 32'h33 is accepted once the lane leaves FULL.
REQ-033 SHALL cover: lane 1 FULL, in_sel=0 -> in_ready=1; a push of 32'h55 lands on lane 0 unaffected by lane 1.
REQ-034 SHALL cover: lane 0 in ONE with push and pop in the same cycle -> lane stays ONE and the pop order is preserved.
REQ-035 SHALL cover: both lanes FULL, assert reset between edges -> out0_valid=out1_valid=0 immediately; the next push after release is delivered first.
REQ-036 SHALL cover, with DEMUX_STAGE_COUNT_EN: 3 pops on lane 0 -> cnt0=3 and cnt1=0; a forced count of 16'hFFFF plus one pop -> cnt0 stays 16'hFFFF.
